// File: rtl/ss_player_mover.sv
`timescale 1ns/1ps
// ss_player_mover
// Per-frame player motion engine. On an accepted frame tick it probes the
// horizontal target tile, then the vertical target tile, through the shared
// world-map read port. It then commits LocX/LocY. A trailing read of the
// committed tile raises hazard_hit or goal_hit.
//
// Ports
//   clk            system clock, shared with the world-map RAM read port
//   reset          asynchronous, active-low
//   tick           1-cycle frame strobe, accepted only while idle
//   move_left      level request, west
//   move_right     level request, east
//   jump           level request, jump
//   map_is_first   1 = first map shown; blocks the west wrap at column 0
//   worldmap_data  tile code: 00 empty, 01 solid, 10 hazard, 11 goal
//   worldmap_addr  {y[6:0], x[6:0]} tile read address
//   LocX, LocY     player column / row (row 0 = top)
//   busy           high from tick acceptance through the COMMIT cycle
//   hazard_hit     1-cycle pulse, committed tile is hazard
//   goal_hit       1-cycle pulse, committed tile is goal
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for tick; the address rests on {LocY, LocX}
// S_H_REQ  | pick horizontal target tx; launch its probe or skip it
// S_H_WAIT | count down RD_LAT; a solid tile cancels the horizontal step
// S_V_REQ  | pick vertical target ty (jump ascent or gravity); probe it
// S_V_WAIT | count down RD_LAT; resolve ceiling/floor contact
// S_COMMIT | LocX/LocY <= tx/ty; arm the hazard/goal check
module ss_player_mover #(
   parameter logic [7:0] START_X = 8'h01,
   parameter logic [7:0] START_Y = 8'h60,
   parameter logic [7:0] EDGE_R  = 8'h7C,
   parameter logic [7:0] WRAP_W  = 8'h7B,
   parameter int         JUMP_H  = 4,
   parameter int         RD_LAT  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        move_left,
   input  logic        move_right,
   input  logic        jump,
   input  logic        map_is_first,
   input  logic [1:0]  worldmap_data,
   output logic [13:0] worldmap_addr,
   output logic [7:0]  LocX,
   output logic [7:0]  LocY,
   output logic        busy,
   output logic        hazard_hit,
   output logic        goal_hit
);

   typedef enum logic [2:0] {
      S_IDLE, S_H_REQ, S_H_WAIT, S_V_REQ, S_V_WAIT, S_COMMIT
   } state_t;

   localparam logic [1:0] TILE_SOLID = 2'b01;

   state_t      state_q, state_d;
   logic [7:0]  locx_q, locx_d, locy_q, locy_d;
   logic [7:0]  tx_q, tx_d, ty_q, ty_d;
   logic [13:0] addr_q, addr_d;
   logic [3:0]  cnt_q, cnt_d, jump_cnt_q, jump_cnt_d, pcnt_q, pcnt_d;
   logic        l_q, l_d, r_q, r_d, j_q, j_d;
   logic        up_q, up_d, grounded_q, grounded_d, chk_q, chk_d;
   logic [7:0]  tx_step, ty_step;
   logic [3:0]  jc_eff;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         locx_q     <= START_X;
         locy_q     <= START_Y;
         tx_q       <= START_X;
         ty_q       <= START_Y;
         addr_q     <= {START_Y[6:0], START_X[6:0]};
         cnt_q      <= '0;
         jump_cnt_q <= '0;
         pcnt_q     <= '0;
         l_q        <= 1'b0;
         r_q        <= 1'b0;
         j_q        <= 1'b0;
         up_q       <= 1'b0;
         grounded_q <= 1'b0;
         chk_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         locx_q     <= locx_d;
         locy_q     <= locy_d;
         tx_q       <= tx_d;
         ty_q       <= ty_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         jump_cnt_q <= jump_cnt_d;
         pcnt_q     <= pcnt_d;
         l_q        <= l_d;
         r_q        <= r_d;
         j_q        <= j_d;
         up_q       <= up_d;
         grounded_q <= grounded_d;
         chk_q      <= chk_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      locx_d     = locx_q;
      locy_d     = locy_q;
      tx_d       = tx_q;
      ty_d       = ty_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      jump_cnt_d = jump_cnt_q;
      pcnt_d     = pcnt_q;
      l_d        = l_q;
      r_d        = r_q;
      j_d        = j_q;
      up_d       = up_q;
      grounded_d = grounded_q;
      chk_d      = chk_q;
      tx_step    = r_q ? locx_q + 8'd1 : locx_q - 8'd1;
      jc_eff     = (j_q && grounded_q && jump_cnt_q == 4'd0) ? 4'(JUMP_H) : jump_cnt_q;
      ty_step    = (jc_eff != 4'd0) ? locy_q - 8'd1 : locy_q + 8'd1;

      // Trailing read of the committed tile; runs alongside the next frame.
      if (chk_q) begin
         if (pcnt_q != 4'd0) pcnt_d = pcnt_q - 4'd1;
         else                chk_d  = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (tick) begin
               l_d     = move_left & ~move_right;
               r_d     = move_right & ~move_left;
               j_d     = jump;
               state_d = S_H_REQ;
            end
         end
         S_H_REQ: begin
            if (r_q && locx_q == EDGE_R) begin
               tx_d    = 8'h01;
               state_d = S_V_REQ;
            end else if (l_q && locx_q == 8'h00) begin
               tx_d    = map_is_first ? locx_q : WRAP_W;
               state_d = S_V_REQ;
            end else if (r_q || l_q) begin
               tx_d    = tx_step;
               addr_d  = {locy_q[6:0], tx_step[6:0]};
               cnt_d   = 4'(RD_LAT);
               state_d = S_H_WAIT;
            end else begin
               tx_d    = locx_q;
               state_d = S_V_REQ;
            end
         end
         S_H_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (worldmap_data == TILE_SOLID) tx_d = locx_q;
               addr_d  = {locy_q[6:0], locx_q[6:0]};
               state_d = S_V_REQ;
            end
         end
         S_V_REQ: begin
            jump_cnt_d = jc_eff;
            up_d       = (jc_eff != 4'd0);
            // Top and bottom rows act as solid without a RAM read.
            if (jc_eff != 4'd0 && locy_q == 8'h00) begin
               jump_cnt_d = 4'd0;
               ty_d       = locy_q;
               state_d    = S_COMMIT;
            end else if (jc_eff == 4'd0 && locy_q == 8'h7F) begin
               grounded_d = 1'b1;
               ty_d       = locy_q;
               state_d    = S_COMMIT;
            end else begin
               ty_d    = ty_step;
               addr_d  = {ty_step[6:0], tx_q[6:0]};
               cnt_d   = 4'(RD_LAT);
               state_d = S_V_WAIT;
            end
         end
         S_V_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (worldmap_data == TILE_SOLID) begin
                  if (up_q) jump_cnt_d = 4'd0;
                  else      grounded_d = 1'b1;
                  ty_d = locy_q;
               end else begin
                  if (up_q) jump_cnt_d = jump_cnt_q - 4'd1;
                  else      grounded_d = 1'b0;
               end
               addr_d  = {locy_q[6:0], locx_q[6:0]};
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            // The committed tile is the new resting address, so the
            // hazard/goal read needs no separate probe.
            locx_d  = tx_q;
            locy_d  = ty_q;
            addr_d  = {ty_q[6:0], tx_q[6:0]};
            chk_d   = 1'b1;
            pcnt_d  = 4'(RD_LAT);
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign worldmap_addr = addr_q;
   assign LocX          = locx_q;
   assign LocY          = locy_q;
   assign busy          = (state_q != S_IDLE);
   assign hazard_hit    = chk_q && (pcnt_q == 4'd0) && (worldmap_data == 2'b10);
   assign goal_hit      = chk_q && (pcnt_q == 4'd0) && (worldmap_data == 2'b11);

endmodule

// File: tb/tb_ss_player_mover.sv
`timescale 1ns/1ps
module tb_ss_player_mover;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        tick = 1'b0;
   logic        move_left = 1'b0;
   logic        move_right = 1'b0;
   logic        jump = 1'b0;
   logic        map_is_first = 1'b0;
   logic [1:0]  worldmap_data;
   logic [13:0] worldmap_addr;
   logic [7:0]  LocX, LocY;
   logic        busy, hazard_hit, goal_hit;

   int n_assert = 0;
   int n_fail   = 0;
   int goal_cnt = 0;
   int haz_cnt  = 0;

   logic [1:0] mem [0:16383];
   logic [1:0] rd_d1 = 2'b00;
   logic [1:0] rd_d2 = 2'b00;

   always #5 clk = ~clk;

   // World-map RAM: data valid two clocks after an address change.
   always @(posedge clk) begin
      rd_d1 <= mem[worldmap_addr];
      rd_d2 <= rd_d1;
   end
   assign worldmap_data = rd_d2;

   always @(negedge clk) begin
      if (goal_hit)   goal_cnt++;
      if (hazard_hit) haz_cnt++;
   end

   ss_player_mover dut (
      .clk(clk), .reset(reset), .tick(tick),
      .move_left(move_left), .move_right(move_right), .jump(jump),
      .map_is_first(map_is_first), .worldmap_data(worldmap_data),
      .worldmap_addr(worldmap_addr), .LocX(LocX), .LocY(LocY),
      .busy(busy), .hazard_hit(hazard_hit), .goal_hit(goal_hit)
   );

   function automatic int idx(input int y, input int x);
      return y * 128 + x;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One tick with the given requests; returns the number of cycles busy was high.
   task automatic frame(input logic ml, input logic mr, input logic jp, output int bcyc);
      @(negedge clk);
      move_left = ml; move_right = mr; jump = jp; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0; move_left = 1'b0; move_right = 1'b0; jump = 1'b0;
      bcyc = 0;
      while (busy && bcyc < 100) begin
         bcyc++;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [7:0] exp_jump [0:8];
   logic [7:0] exp_ceil [0:3];
   int bc, g0, h0;

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 2'b00;
      for (int x = 0; x < 128; x++) mem[idx(8'h61, x)] = 2'b01;
      exp_jump[0] = 8'h5F; exp_jump[1] = 8'h5E; exp_jump[2] = 8'h5D;
      exp_jump[3] = 8'h5C; exp_jump[4] = 8'h5D; exp_jump[5] = 8'h5E;
      exp_jump[6] = 8'h5F; exp_jump[7] = 8'h60; exp_jump[8] = 8'h60;
      exp_ceil[0] = 8'h5F; exp_ceil[1] = 8'h5F; exp_ceil[2] = 8'h60;
      exp_ceil[3] = 8'h60;

      repeat (3) @(negedge clk);
      check("rst_locx", {24'd0, LocX}, 32'h01);
      check("rst_locy", {24'd0, LocY}, 32'h60);
      check("rst_addr", {18'd0, worldmap_addr}, {18'd0, 7'h60, 7'h01});
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_pulses", {30'd0, hazard_hit, goal_hit}, 32'd0);
      reset = 1'b1;

      // Step east on the floor; first frame also lands the player.
      g0 = goal_cnt; h0 = haz_cnt;
      frame(1'b0, 1'b1, 1'b0, bc);
      check("r_locx", {24'd0, LocX}, 32'h02);
      check("r_locy", {24'd0, LocY}, 32'h60);
      check("r_busy_cycles", bc, 9);
      check("r_addr_rest", {18'd0, worldmap_addr}, {18'd0, 7'h60, 7'h02});
      check("r_no_pulse", goal_cnt - g0 + haz_cnt - h0, 0);

      // Wall at (60,03)
      mem[idx(8'h60, 8'h03)] = 2'b01;
      frame(1'b0, 1'b1, 1'b0, bc);
      check("wall_locx", {24'd0, LocX}, 32'h02);
      check("wall_busy_cycles", bc, 9);
      mem[idx(8'h60, 8'h03)] = 2'b00;

      // Both directions -> no horizontal move, no horizontal probe
      frame(1'b1, 1'b1, 1'b0, bc);
      check("lr_locx", {24'd0, LocX}, 32'h02);
      check("lr_busy_cycles", bc, 6);

      frame(1'b1, 1'b0, 1'b0, bc);
      check("l1_locx", {24'd0, LocX}, 32'h01);
      frame(1'b1, 1'b0, 1'b0, bc);
      check("l0_locx", {24'd0, LocX}, 32'h00);

      map_is_first = 1'b1;
      frame(1'b1, 1'b0, 1'b0, bc);
      check("west_blocked_locx", {24'd0, LocX}, 32'h00);
      check("west_blocked_cycles", bc, 6);

      map_is_first = 1'b0;
      frame(1'b1, 1'b0, 1'b0, bc);
      check("west_wrap_locx", {24'd0, LocX}, 32'h7B);
      check("west_wrap_cycles", bc, 6);

      frame(1'b0, 1'b1, 1'b0, bc);
      check("to_edge_locx", {24'd0, LocX}, 32'h7C);
      frame(1'b0, 1'b1, 1'b0, bc);
      check("east_tp_locx", {24'd0, LocX}, 32'h01);
      check("east_tp_cycles", bc, 6);
      check("east_tp_addr", {18'd0, worldmap_addr}, {18'd0, 7'h60, 7'h01});

      // Jump of four rows, then gravity back to the floor
      for (int k = 0; k < 9; k++) begin
         frame(1'b0, 1'b0, (k == 0), bc);
         check($sformatf("jump_locy_%0d", k), {24'd0, LocY}, {24'd0, exp_jump[k]});
      end

      // Ceiling at row 5E above the player
      mem[idx(8'h5E, 8'h01)] = 2'b01;
      for (int k = 0; k < 4; k++) begin
         frame(1'b0, 1'b0, (k == 0), bc);
         check($sformatf("ceil_locy_%0d", k), {24'd0, LocY}, {24'd0, exp_ceil[k]});
      end
      mem[idx(8'h5E, 8'h01)] = 2'b00;

      // Second tick while busy must be dropped
      @(negedge clk);
      move_right = 1'b1; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("drop_busy_when_retick", {31'd0, busy}, 32'd1);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0; move_right = 1'b0;
      repeat (25) @(negedge clk);
      check("drop_locx", {24'd0, LocX}, 32'h02);
      check("drop_idle", {31'd0, busy}, 32'd0);

      // Goal then hazard at the target tile
      mem[idx(8'h60, 8'h03)] = 2'b11;
      g0 = goal_cnt; h0 = haz_cnt;
      frame(1'b0, 1'b1, 1'b0, bc);
      check("goal_locx", {24'd0, LocX}, 32'h03);
      check("goal_pulses", goal_cnt - g0, 1);
      check("goal_no_hazard", haz_cnt - h0, 0);
      mem[idx(8'h60, 8'h04)] = 2'b10;
      g0 = goal_cnt; h0 = haz_cnt;
      frame(1'b0, 1'b1, 1'b0, bc);
      check("hazard_locx", {24'd0, LocX}, 32'h04);
      check("hazard_pulses", haz_cnt - h0, 1);
      check("hazard_no_goal", goal_cnt - g0, 0);

      // Reset during V_WAIT: six clocks after acceptance
      @(negedge clk);
      move_right = 1'b1; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0; move_right = 1'b0;
      repeat (5) @(negedge clk);
      check("midframe_busy", {31'd0, busy}, 32'd1);
      check("midframe_locx_held", {24'd0, LocX}, 32'h04);
      reset = 1'b0;
      #1;
      check("abort_locx", {24'd0, LocX}, 32'h01);
      check("abort_locy", {24'd0, LocY}, 32'h60);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_addr", {18'd0, worldmap_addr}, {18'd0, 7'h60, 7'h01});
      repeat (2) @(negedge clk);
      reset = 1'b1;
      frame(1'b0, 1'b1, 1'b0, bc);
      check("post_reset_locx", {24'd0, LocX}, 32'h02);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
